// File: rtl/hs_rr_arbiter.sv
// rtl/hs_rr_arbiter.sv - round-robin NUM_IN:1 valid/ready arbiter with one registered output stage
// Optional packet lock (grant held until last) is built when HS_RR_ARBITER_LOCK_EN is defined.
module hs_rr_arbiter #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 64,
  parameter int SRC_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        rx_hs_valid,
  output logic [NUM_IN-1:0]        rx_hs_ready,
  input  logic [NUM_IN*DATA_W-1:0] rx_hs_data,
`ifdef HS_RR_ARBITER_LOCK_EN
  input  logic [NUM_IN-1:0]        rx_hs_last,
  output logic                     tx_hs_last,
`endif
  input  logic                     tx_hs_ready,
  output logic                     tx_hs_valid,
  output logic [DATA_W-1:0]        tx_hs_data,
  output logic [SRC_W-1:0]         tx_hs_src
);

  logic              adv;
  logic [SRC_W-1:0]  rr_ptr;
  logic [NUM_IN-1:0] eligible;
  logic              found;
  logic [SRC_W-1:0]  grant_idx;
  logic [SRC_W-1:0]  scan;
  logic [DATA_W-1:0] sel_data;
  logic              xfer;

  assign adv  = !tx_hs_valid || tx_hs_ready;
  assign xfer = adv && found;

`ifdef HS_RR_ARBITER_LOCK_EN
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]       state;
  logic [SRC_W-1:0] lock_idx;

  // While a packet is in flight only its owner may be granted.
  always_comb begin
    eligible = rx_hs_valid;
    if (state == ST_LOCKED) begin
      eligible = rx_hs_valid & (NUM_IN'(1) << lock_idx);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      lock_idx   <= '0;
      tx_hs_last <= 1'b0;
    end else if (xfer) begin
      tx_hs_last <= rx_hs_last[grant_idx];
      if (state == ST_IDLE) begin
        if (!rx_hs_last[grant_idx]) begin
          state    <= ST_LOCKED;
          lock_idx <= grant_idx;
        end
      end else if (rx_hs_last[grant_idx]) begin
        state <= ST_IDLE;
      end
    end
  end
`else
  assign eligible = rx_hs_valid;
`endif

  // Scan starts just past the last winner, so the last winner has lowest priority.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      scan = SRC_W'((int'(rr_ptr) + k) % NUM_IN);
      if (!found && eligible[scan]) begin
        found     = 1'b1;
        grant_idx = scan;
      end
    end
  end

  always_comb begin
    rx_hs_ready = '0;
    if (xfer) begin
      rx_hs_ready[grant_idx] = 1'b1;
    end
  end

  assign sel_data = rx_hs_data[int'(grant_idx)*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_hs_valid <= 1'b0;
      tx_hs_data  <= '0;
      tx_hs_src   <= '0;
      rr_ptr      <= SRC_W'(NUM_IN - 1);
    end else if (adv) begin
      tx_hs_valid <= found;
      if (found) begin
        tx_hs_data <= sel_data;
        tx_hs_src  <= grant_idx;
        rr_ptr     <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// tb/tb_hs_rr_arbiter.sv - randomized and directed checks of hs_rr_arbiter against a behavioural model
// Lock scenarios are included when HS_RR_ARBITER_LOCK_EN is defined.
module tb_hs_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  rx_hs_valid = '0;
  logic [N-1:0]  rx_hs_ready;
  logic [N*DW-1:0] rx_hs_data = '0;
  logic          tx_hs_ready = 1'b0;
  logic          tx_hs_valid;
  logic [DW-1:0] tx_hs_data;
  logic [SW-1:0] tx_hs_src;
`ifdef HS_RR_ARBITER_LOCK_EN
  logic [N-1:0]  rx_hs_last = '1;
  logic          tx_hs_last;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Model: output register contents, last winner, packet-lock status, and an in-order word queue.
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_src;
  int            m_last_grant;
  bit            m_locked;
  int            m_lock_idx;
  bit            m_tlast;
  logic [DW-1:0] sb_data[$];
  int            sb_src[$];

  hs_rr_arbiter #(.NUM_IN(N), .DATA_W(DW), .SRC_W(SW)) dut (
    .clk(clk),
    .rst(rst),
    .rx_hs_valid(rx_hs_valid),
    .rx_hs_ready(rx_hs_ready),
    .rx_hs_data(rx_hs_data),
`ifdef HS_RR_ARBITER_LOCK_EN
    .rx_hs_last(rx_hs_last),
    .tx_hs_last(tx_hs_last),
`endif
    .tx_hs_ready(tx_hs_ready),
    .tx_hs_valid(tx_hs_valid),
    .tx_hs_data(tx_hs_data),
    .tx_hs_src(tx_hs_src)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  function automatic void model_reset();
    m_valid = 0; m_data = '0; m_src = 0; m_last_grant = N - 1;
    m_locked = 0; m_lock_idx = 0; m_tlast = 0;
    sb_data.delete(); sb_src.delete();
  endfunction

  function automatic int model_pick();
    if (m_valid && !tx_hs_ready) return -1;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_last_grant + k) % N;
      if (rx_hs_valid[j] && (!m_locked || j == m_lock_idx)) return j;
    end
    return -1;
  endfunction

  task automatic do_cycle(input string tag, output int g);
    logic [N-1:0]  exp_rdy;
    logic [DW-1:0] exp_d;
    int            exp_s;
    bit            lst;
    g = model_pick();
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    #1;
    n_cmp++;
    if (rx_hs_ready !== exp_rdy) begin
      n_err++; $display("FAIL %s rx_hs_ready got %b exp %b", tag, rx_hs_ready, exp_rdy);
    end
    if (tx_hs_valid && tx_hs_ready) begin
      n_cmp++;
      if (sb_data.size() == 0) begin
        n_err++; $display("FAIL %s sb output word with empty queue src %0d", tag, tx_hs_src);
      end else begin
        exp_d = sb_data.pop_front(); exp_s = sb_src.pop_front();
        if (tx_hs_data !== exp_d || int'(tx_hs_src) !== exp_s) begin
          n_err++; $display("FAIL %s sb got %h/%0d exp %h/%0d", tag, tx_hs_data, tx_hs_src, exp_d, exp_s);
        end
      end
    end
    if (!m_valid || tx_hs_ready) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_data = rx_hs_data[g*DW +: DW];
        m_src = g;
        m_last_grant = g;
        sb_data.push_back(m_data); sb_src.push_back(g);
`ifdef HS_RR_ARBITER_LOCK_EN
        lst = rx_hs_last[g];
`else
        lst = 1'b1;
`endif
        m_tlast = lst;
        if (!m_locked && !lst) begin m_locked = 1; m_lock_idx = g; end
        else if (m_locked && lst) m_locked = 0;
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (tx_hs_valid !== m_valid || tx_hs_data !== m_data || int'(tx_hs_src) !== m_src) begin
      n_err++; $display("FAIL %s out got v%b %h/%0d exp v%b %h/%0d", tag, tx_hs_valid, tx_hs_data,
                        tx_hs_src, m_valid, m_data, m_src);
    end
`ifdef HS_RR_ARBITER_LOCK_EN
    n_cmp++;
    if (tx_hs_last !== m_tlast) begin
      n_err++; $display("FAIL %s tx_hs_last got %b exp %b", tag, tx_hs_last, m_tlast);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0; rx_hs_valid = '0; tx_hs_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (tx_hs_valid !== 1'b0 || tx_hs_data !== '0 || tx_hs_src !== '0 || rx_hs_ready !== '0) begin
      n_err++; $display("FAIL reset got v%b d%h s%0d r%b exp 0", tx_hs_valid, tx_hs_data, tx_hs_src, rx_hs_ready);
    end
    rst = 1'b1;
  endtask

  task automatic test_priority();
    int g;
    for (int i = 0; i < N; i++) rx_hs_data[i*DW +: DW] = 64'hA0 + 64'(i);
    rx_hs_valid = '1; tx_hs_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      do_cycle("priority", g);
      n_cmp++;
      if (tx_hs_valid !== 1'b1 || int'(tx_hs_src) !== k % N || tx_hs_data !== 64'hA0 + 64'(k % N)) begin
        n_err++; $display("FAIL priority step %0d got %0d/%h exp %0d/%h", k, tx_hs_src, tx_hs_data,
                          k % N, 64'hA0 + 64'(k % N));
      end
    end
  endtask

  task automatic test_sparse();
    int g;
    int exp_seq[4] = '{1, 3, 1, 3};
    rx_hs_valid = 4'b1010; tx_hs_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      do_cycle("sparse", g);
      n_cmp++;
      if (int'(tx_hs_src) !== exp_seq[k] || rx_hs_ready[0] !== 1'b0 || rx_hs_ready[2] !== 1'b0) begin
        n_err++; $display("FAIL sparse step %0d got src %0d rdy %b exp src %0d", k, tx_hs_src, rx_hs_ready, exp_seq[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int g, held_s;
    logic [DW-1:0] held_d;
    rx_hs_valid = '1; tx_hs_ready = 1'b1;
    do_cycle("bp_fill", g);
    held_s = m_src; held_d = m_data;
    tx_hs_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      do_cycle("bp_stall", g);
      n_cmp++;
      if (rx_hs_ready !== '0 || tx_hs_valid !== 1'b1 || int'(tx_hs_src) !== held_s || tx_hs_data !== held_d) begin
        n_err++; $display("FAIL bp_hold got r%b v%b %0d/%h exp r0 v1 %0d/%h", rx_hs_ready, tx_hs_valid,
                          tx_hs_src, tx_hs_data, held_s, held_d);
      end
    end
    tx_hs_ready = 1'b1;
    do_cycle("bp_release", g);
    n_cmp++;
    if (tx_hs_valid !== 1'b1 || int'(tx_hs_src) !== (held_s + 1) % N) begin
      n_err++; $display("FAIL bp_next got v%b src %0d exp v1 src %0d", tx_hs_valid, tx_hs_src, (held_s + 1) % N);
    end
  endtask

  task automatic test_idle_drain();
    int g;
    tx_hs_ready = 1'b1;
    rx_hs_valid = 4'b0100; rx_hs_data[2*DW +: DW] = 64'h55;
    do_cycle("drain_word", g);
    n_cmp++;
    if (tx_hs_valid !== 1'b1 || tx_hs_data !== 64'h55 || tx_hs_src !== 2'd2) begin
      n_err++; $display("FAIL drain_word got v%b %h/%0d exp v1 55/2", tx_hs_valid, tx_hs_data, tx_hs_src);
    end
    rx_hs_valid = '0;
    for (int k = 0; k < 2; k++) begin
      do_cycle("drain_idle", g);
      n_cmp++;
      if (tx_hs_valid !== 1'b0 || tx_hs_data !== 64'h55 || tx_hs_src !== 2'd2) begin
        n_err++; $display("FAIL drain_idle got v%b %h/%0d exp v0 55/2", tx_hs_valid, tx_hs_data, tx_hs_src);
      end
    end
  endtask

  task automatic test_async_reset();
    int g;
    rx_hs_valid = '1; tx_hs_ready = 1'b1;
    do_cycle("ar_fill", g);
    do_cycle("ar_fill", g);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (tx_hs_valid !== 1'b0 || tx_hs_data !== '0 || tx_hs_src !== '0) begin
      n_err++; $display("FAIL async_reset got v%b %h/%0d exp 0", tx_hs_valid, tx_hs_data, tx_hs_src);
    end
    rx_hs_valid = '0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    rx_hs_valid = '1;
    do_cycle("ar_after", g);
    n_cmp++;
    if (tx_hs_valid !== 1'b1 || tx_hs_src !== 2'd0) begin
      n_err++; $display("FAIL ar_after got v%b src %0d exp v1 src 0", tx_hs_valid, tx_hs_src);
    end
  endtask

  task automatic test_random();
    bit            pend[N];
    logic [DW-1:0] pd[N];
    bit            pl[N];
    int            g;
    for (int i = 0; i < N; i++) begin pend[i] = 0; pd[i] = '0; pl[i] = 1; end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1; pd[i] = {$urandom, $urandom}; pl[i] = ($urandom_range(0, 2) != 0);
        end
        rx_hs_valid[i] = pend[i];
        rx_hs_data[i*DW +: DW] = pd[i];
`ifdef HS_RR_ARBITER_LOCK_EN
        rx_hs_last[i] = pl[i];
`endif
      end
      tx_hs_ready = ($urandom_range(0, 3) != 0);
      do_cycle("random", g);
      if (g >= 0) pend[g] = 0;
    end
    rx_hs_valid = '0; tx_hs_ready = 1'b1;
    do_cycle("rand_drain", g);
    do_cycle("rand_drain", g);
    n_cmp++;
    if (sb_data.size() != 0) begin
      n_err++; $display("FAIL rand_drain queue left %0d words exp 0", sb_data.size());
    end
  endtask

`ifdef HS_RR_ARBITER_LOCK_EN
  task automatic test_lock_packet();
    int g;
    int exp_s[4] = '{1, 1, 1, 0};
    bit exp_l[4] = '{0, 0, 1, 1};
    test_reset();
    rx_hs_last = '1; tx_hs_ready = 1'b1;
    rx_hs_valid = 4'b0001;
    do_cycle("lock_pre", g);
    rx_hs_valid = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      rx_hs_last = (k == 2 || k == 3) ? 4'b1111 : 4'b1101;
      do_cycle("lock_pkt", g);
      n_cmp++;
      if (int'(tx_hs_src) !== exp_s[k] || tx_hs_last !== exp_l[k]) begin
        n_err++; $display("FAIL lock_pkt step %0d got %0d/%b exp %0d/%b", k, tx_hs_src, tx_hs_last, exp_s[k], exp_l[k]);
      end
    end
  endtask

  task automatic test_lock_single();
    int g;
    rx_hs_last = '1; rx_hs_valid = 4'b0011; tx_hs_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      do_cycle("lock_single", g);
      n_cmp++;
      if (int'(tx_hs_src) !== ((k % 2 == 0) ? 1 : 0)) begin
        n_err++; $display("FAIL lock_single step %0d got %0d exp %0d", k, tx_hs_src, (k % 2 == 0) ? 1 : 0);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_priority();
    test_sparse();
    test_backpressure();
    test_idle_drain();
    test_async_reset();
    test_random();
`ifdef HS_RR_ARBITER_LOCK_EN
    test_lock_packet();
    test_lock_single();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
